// File: rtl/dac_pkg.sv
// Shared types and constants for the multi-channel DAC command parser.
// States, reply/command ASCII codes and I2C write-word field layout.
package dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_CH,
        GET_BITS,
        LOAD,
        WAIT_START,
        WAIT_END,
        REPLY
    } state_t;

    localparam logic [7:0] CMD_V = 8'h56;
    localparam logic [7:0] ACK_K = 8'h4B;
    localparam logic [7:0] ERR_E = 8'h45;
    localparam logic [7:0] ERR_T = 8'h54;

    // I2C write word: channel in the top nibble, left-aligned code below.
    localparam int CH_LSB   = 12;
    localparam int CH_W     = 4;
    localparam int CODE_LSB = 0;
    localparam int CODE_W   = 12;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII classifier: rx_byte -> is_digit ('0'..'9'),
// is_bit ('0'/'1') and the digit value (0 when not a digit).
module ascii_digit_decode (
    input  logic [7:0] rx_byte,
    output logic       is_digit,
    output logic       is_bit,
    output logic [3:0] value
);

    always_comb begin
        is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        is_bit   = (rx_byte == 8'h30) || (rx_byte == 8'h31);
        value    = 4'd0;
        if (is_digit) begin
            value = rx_byte[3:0];
        end
    end

endmodule

// File: rtl/dac_cmd_fsm_multi.sv
// UART command parser driving one two-byte I2C DAC write per 'V' command.
// Ports: clk/rst (sync, active high); UART_Rx/UART_DataReady in;
// UART_Tx/UART_TxLoad reply out; I2C addr/data/bytes/r_w/load out;
// I2CBusy/I2CDataReady in; cmd_error sticky error flag out.
module dac_cmd_fsm_multi
    import dac_pkg::*;
#(
    parameter int         CHANNELS       = 4,
    parameter int         DATA_BITS      = 12,
    parameter logic [6:0] DAC_ADDR       = 7'h4C,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  UART_Rx,
    input  logic        UART_DataReady,
    output logic [7:0]  UART_Tx,
    output logic        UART_TxLoad,
    output logic [6:0]  I2Caddr,
    output logic [15:0] I2Cdata,
    output logic        I2Cbytes,
    output logic        I2Cr_w,
    output logic        I2C_load,
    input  logic        I2CBusy,
    input  logic        I2CDataReady,
    output logic        cmd_error
);

    localparam int SHIFT = CODE_W - DATA_BITS;
    localparam logic [3:0] CNT_FULL = 4'(DATA_BITS);
    // The reply takes two more clocks (REPLY state, then the registered
    // strobe), so the timeout decision is made that much earlier.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 3);

    state_t      state;
    logic [11:0] sreg;
    logic [3:0]  cnt;
    logic [3:0]  chan;
    logic [7:0]  reply;
    logic [31:0] timer;

    logic        d_is_digit;
    logic        d_is_bit;
    logic [3:0]  d_value;
    logic        is_v;
    logic        ch_ok;
    logic        timed_out;
    logic        unused_in;

    ascii_digit_decode u_dec (
        .rx_byte  (UART_Rx),
        .is_digit (d_is_digit),
        .is_bit   (d_is_bit),
        .value    (d_value)
    );

    assign I2Caddr   = DAC_ADDR;
    assign is_v      = (UART_Rx == CMD_V);
    assign ch_ok     = d_is_digit && (int'(d_value) < CHANNELS);
    assign timed_out = (timer == TO_LAST);
    assign unused_in = I2CDataReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            UART_Tx     <= 8'd0;
            UART_TxLoad <= 1'b0;
            I2Cdata     <= 16'd0;
            I2Cbytes    <= 1'b1;
            I2Cr_w      <= 1'b0;
            I2C_load    <= 1'b0;
            cmd_error   <= 1'b0;
            sreg        <= 12'd0;
            cnt         <= 4'd0;
            chan        <= 4'd0;
            reply       <= 8'd0;
            timer       <= 32'd0;
        end else begin
            I2C_load    <= 1'b0;
            UART_TxLoad <= 1'b0;
            I2Cbytes    <= 1'b1;
            I2Cr_w      <= 1'b0;
            timer       <= timer + 32'd1;
            unique case (state)
                IDLE: begin
                    timer <= 32'd0;
                    if (UART_DataReady && is_v) begin
                        state <= GET_CH;
                    end
                end
                GET_CH: begin
                    if (UART_DataReady) begin
                        timer <= 32'd0;
                        if (is_v) begin
                            state <= GET_CH;
                        end else if (ch_ok) begin
                            chan  <= d_value;
                            cnt   <= 4'd0;
                            sreg  <= 12'd0;
                            state <= GET_BITS;
                        end else begin
                            reply <= ERR_E;
                            state <= REPLY;
                        end
                    end else if (timed_out) begin
                        reply <= ERR_T;
                        state <= REPLY;
                    end
                end
                GET_BITS: begin
                    if (cnt == CNT_FULL) begin
                        // Data is registered on the way into LOAD so the
                        // strobe and the word appear together.
                        I2Cdata  <= {chan, 12'(sreg << SHIFT)};
                        I2C_load <= 1'b1;
                        timer    <= 32'd0;
                        state    <= LOAD;
                    end else if (UART_DataReady) begin
                        timer <= 32'd0;
                        if (is_v) begin
                            state <= GET_CH;
                        end else if (d_is_bit) begin
                            sreg <= {sreg[10:0], UART_Rx[0]};
                            cnt  <= cnt + 4'd1;
                        end else begin
                            reply <= ERR_E;
                            state <= REPLY;
                        end
                    end else if (timed_out) begin
                        reply <= ERR_T;
                        state <= REPLY;
                    end
                end
                LOAD: begin
                    timer <= 32'd0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (I2CBusy) begin
                        timer <= 32'd0;
                        state <= WAIT_END;
                    end else if (timed_out) begin
                        reply <= ERR_T;
                        state <= REPLY;
                    end
                end
                WAIT_END: begin
                    if (!I2CBusy) begin
                        reply <= ACK_K;
                        state <= REPLY;
                    end else if (timed_out) begin
                        reply <= ERR_T;
                        state <= REPLY;
                    end
                end
                REPLY: begin
                    UART_Tx     <= reply;
                    UART_TxLoad <= 1'b1;
                    cmd_error   <= (reply != ACK_K);
                    timer       <= 32'd0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_cmd_fsm_multi.sv
// Self-checking bench for dac_cmd_fsm_multi: directed scenarios plus
// randomized commands compared against a command-level reference model.
module tb_dac_cmd_fsm_multi;

    localparam int CH = 4;
    localparam int DB = 12;
    localparam int TO = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rx;
    logic       rdy;
    logic       busy;
    logic       busy_en;

    logic [7:0]  a_tx;
    logic        a_txl;
    logic [6:0]  a_addr;
    logic [15:0] a_data;
    logic        a_bytes;
    logic        a_rw;
    logic        a_load;
    logic        a_err;

    logic [7:0]  b_tx;
    logic        b_txl;
    logic [6:0]  b_addr;
    logic [15:0] b_data;
    logic        b_bytes;
    logic        b_rw;
    logic        b_load;
    logic        b_err;

    dac_cmd_fsm_multi #(
        .CHANNELS(CH), .DATA_BITS(DB),
        .DAC_ADDR(7'h4C), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .UART_Rx(rx), .UART_DataReady(rdy),
        .UART_Tx(a_tx), .UART_TxLoad(a_txl),
        .I2Caddr(a_addr), .I2Cdata(a_data),
        .I2Cbytes(a_bytes), .I2Cr_w(a_rw),
        .I2C_load(a_load), .I2CBusy(busy),
        .I2CDataReady(1'b0), .cmd_error(a_err)
    );

    dac_cmd_fsm_multi #(
        .CHANNELS(CH), .DATA_BITS(8),
        .DAC_ADDR(7'h4C), .TIMEOUT_CYCLES(TO)
    ) dut8 (
        .clk(clk), .rst(rst),
        .UART_Rx(rx), .UART_DataReady(rdy),
        .UART_Tx(b_tx), .UART_TxLoad(b_txl),
        .I2Caddr(b_addr), .I2Cdata(b_data),
        .I2Cbytes(b_bytes), .I2Cr_w(b_rw),
        .I2C_load(b_load), .I2CBusy(busy),
        .I2CDataReady(1'b0), .cmd_error(b_err)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int strobe_cyc = 0;
    int load_cnt = 0;
    int load_cyc = 0;
    logic [15:0] load_word = 16'd0;
    int tx_cnt = 0;
    int tx_cyc = 0;
    logic [7:0] tx_byte = 8'd0;
    int b_load_cnt = 0;
    int b_load_cyc = 0;
    logic [15:0] b_word = 16'd0;
    int fall_cyc = 0;
    logic prev_busy = 1'b0;
    int bdly = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy) strobe_cyc <= cyc;
        if (a_load) begin
            load_cnt  <= load_cnt + 1;
            load_cyc  <= cyc;
            load_word <= a_data;
        end
        if (a_txl) begin
            tx_cnt  <= tx_cnt + 1;
            tx_cyc  <= cyc;
            tx_byte <= a_tx;
        end
        if (b_load) begin
            b_load_cnt <= b_load_cnt + 1;
            b_load_cyc <= cyc;
            b_word     <= b_data;
        end
        if (prev_busy && !busy) fall_cyc <= cyc;
        prev_busy <= busy;
    end

    // I2C master model: busy rises a few clocks after load, lasts 20.
    always @(posedge clk) begin
        if (rst) begin
            bdly <= 0;
            busy <= 1'b0;
        end else if (a_load && busy_en) begin
            bdly <= 1;
        end else if (bdly != 0) begin
            bdly <= bdly + 1;
            if (bdly == 2) busy <= 1'b1;
            if (bdly == 22) begin
                busy <= 1'b0;
                bdly <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx  = b;
        rdy = 1'b1;
        @(posedge clk);
        #1;
        rdy = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic wait_tx(input int t0, input int budget);
        int n;
        n = 0;
        while (tx_cnt == t0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("tx_seen", 32'(tx_cnt - t0), 1);
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!busy && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("busy_seen", {31'd0, busy}, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Command-level model: first complete command or first bad byte wins.
    function automatic void ref_model(input logic [7:0] q[$],
                                      output bit is_err,
                                      output logic [15:0] word);
        bit active;
        int ch;
        int n;
        logic [11:0] code;
        active = 0;
        ch = -1;
        n = 0;
        code = 12'd0;
        is_err = 0;
        word = 16'd0;
        foreach (q[i]) begin
            if (q[i] == "V") begin
                active = 1;
                ch = -1;
                n = 0;
                code = 12'd0;
            end else if (active) begin
                if (ch < 0) begin
                    if (q[i] >= "0" && int'(q[i]) < 48 + CH) begin
                        ch = int'(q[i]) - 48;
                    end else begin
                        is_err = 1;
                        return;
                    end
                end else if (q[i] == "0" || q[i] == "1") begin
                    code = code * 2 + 12'(q[i] - "0");
                    n++;
                    if (n == DB) begin
                        word = (16'(ch) << 12) | 16'(code << (12 - DB));
                        return;
                    end
                end else begin
                    is_err = 1;
                    return;
                end
            end
        end
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int l0;
        bit e;
        logic [15:0] w;
        logic [7:0] q[$];
        string s;

        rst = 1'b1;
        rx = 8'd0;
        rdy = 1'b0;
        busy_en = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_tx", a_tx, 0);
        chk("rst_txl", a_txl, 0);
        chk("rst_data", a_data, 0);
        chk("rst_bytes", a_bytes, 1);
        chk("rst_rw", a_rw, 0);
        chk("rst_load", a_load, 0);
        chk("rst_err", a_err, 0);
        chk("rst_addr", a_addr, 7'h4C);

        busy_en = 1'b1;
        t0 = tx_cnt;
        l0 = load_cnt;
        send_str("V2101010101010");
        wait_tx(t0, 200);
        chk("d1_loads", 32'(load_cnt - l0), 1);
        chk("d1_word", load_word, 16'h2AAA);
        chk("d1_lat", 32'(load_cyc - strobe_cyc), 2);
        chk("d1_rw", a_rw, 0);
        chk("d1_bytes", a_bytes, 1);
        chk("d1_addr", a_addr, 7'h4C);
        chk("d1_reply", tx_byte, 8'h4B);
        chk("d1_k_lat", 32'(tx_cyc - fall_cyc), 2);
        chk("d1_err", a_err, 0);

        do_reset();
        l0 = b_load_cnt;
        send_str("V111110000");
        repeat (5) @(posedge clk);
        chk("b_loads", 32'(b_load_cnt - l0), 1);
        chk("b_word", b_word, 16'h1F00);
        chk("b_lat", 32'(b_load_cyc - strobe_cyc), 2);
        do_reset();

        t0 = tx_cnt;
        l0 = load_cnt;
        send_str("V7");
        wait_tx(t0, 50);
        chk("ch_reply", tx_byte, 8'h45);
        chk("ch_err", a_err, 1);
        chk("ch_noload", 32'(load_cnt - l0), 0);
        t0 = tx_cnt;
        send_str("V1110011001100");
        wait_tx(t0, 200);
        chk("ch_k", tx_byte, 8'h4B);
        chk("ch_err_clr", a_err, 0);
        chk("ch_word", load_word, 16'h1CCC);

        t0 = tx_cnt;
        l0 = load_cnt;
        send_str("V010V3111111111111");
        wait_tx(t0, 200);
        chk("rs_loads", 32'(load_cnt - l0), 1);
        chk("rs_word", load_word, 16'h3FFF);
        chk("rs_reply", tx_byte, 8'h4B);

        t0 = tx_cnt;
        l0 = load_cnt;
        send_str("V110x");
        wait_tx(t0, 50);
        chk("x_reply", tx_byte, 8'h45);
        chk("x_noload", 32'(load_cnt - l0), 0);
        chk("x_err", a_err, 1);

        t0 = tx_cnt;
        send_str("V0");
        wait_tx(t0, 100);
        chk("to_reply", tx_byte, 8'h54);
        chk("to_lat", 32'(tx_cyc - strobe_cyc), TO);
        chk("to_err", a_err, 1);

        busy_en = 1'b0;
        t0 = tx_cnt;
        l0 = load_cnt;
        send_str("V2000000000001");
        wait_tx(t0, 150);
        chk("tw_loads", 32'(load_cnt - l0), 1);
        chk("tw_reply", tx_byte, 8'h54);
        chk("tw_lat", 32'(tx_cyc - load_cyc), TO);

        busy_en = 1'b1;
        t0 = tx_cnt;
        l0 = load_cnt;
        send_str("V3111100001111");
        wait_busy(20);
        send_str("V1");
        wait_tx(t0, 100);
        chk("bz_reply", tx_byte, 8'h4B);
        chk("bz_word", load_word, 16'h3F0F);
        repeat (70) @(posedge clk);
        chk("bz_txs", 32'(tx_cnt - t0), 1);
        chk("bz_loads", 32'(load_cnt - l0), 1);
        chk("bz_err", a_err, 0);

        t0 = tx_cnt;
        send_str("Vz");
        wait_tx(t0, 50);
        chk("z_err", a_err, 1);
        t0 = tx_cnt;
        l0 = load_cnt;
        send_str("V1000011110000");
        wait_busy(20);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_txl", a_txl, 0);
        chk("mr_load", a_load, 0);
        chk("mr_data", a_data, 0);
        chk("mr_tx", a_tx, 0);
        chk("mr_err", a_err, 0);
        repeat (70) @(posedge clk);
        chk("mr_txs", 32'(tx_cnt - t0), 0);
        chk("mr_loads", 32'(load_cnt - l0), 1);

        for (int it = 0; it < 12; it++) begin
            int ch;
            int badpos;
            q.delete();
            q.push_back("V");
            ch = $urandom_range(0, 5);
            q.push_back(8'(48 + ch));
            badpos = ($urandom_range(0, 3) == 0) ?
                     int'($urandom_range(0, DB - 1)) : -1;
            for (int k = 0; k < DB; k++) begin
                if (k == badpos) q.push_back("x");
                else q.push_back(8'(48 + $urandom_range(0, 1)));
            end
            ref_model(q, e, w);
            t0 = tx_cnt;
            l0 = load_cnt;
            foreach (q[i]) send(q[i]);
            wait_tx(t0, 200);
            if (e) begin
                chk($sformatf("rnd%0d_e", it), tx_byte, 8'h45);
                chk($sformatf("rnd%0d_nl", it),
                    32'(load_cnt - l0), 0);
                chk($sformatf("rnd%0d_ef", it), a_err, 1);
            end else begin
                chk($sformatf("rnd%0d_k", it), tx_byte, 8'h4B);
                chk($sformatf("rnd%0d_w", it), load_word, w);
                chk($sformatf("rnd%0d_l", it),
                    32'(load_cnt - l0), 1);
                chk($sformatf("rnd%0d_ef", it), a_err, 0);
            end
            repeat (3) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_cmd_fsm_multi.md
Name: dac_cmd_fsm_multi

Overview:
Parametrised successor to the single-channel DAC control FSM. Parses ASCII commands from the UART receiver of the form 'V', channel digit, then DATA_BITS binary digits ('1'/'0', MSB first). It converts each command into one two-byte I2C write to a multi-channel DAC and reports the result over UART. It sits between the UART RX/TX blocks and the I2C master, and adds channel select, error detection, restart and timeouts.

Parameters:
CHANNELS, 4, number of DAC channels; legal range 1..10 (channel digits '0'..'9').
DATA_BITS, 12, code width in binary digits; legal range 1..12.
DAC_ADDR, 7'h4C, 7-bit I2C slave address.
TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes, and for each I2C phase.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
UART_Rx  in  8  received byte, valid when UART_DataReady=1
UART_DataReady  in  1  one-cycle strobe per received byte
UART_Tx  out  8  reply byte
UART_TxLoad  out  1  one-cycle strobe; UART_Tx is valid in that cycle and held afterwards
I2Caddr  out  7  slave address, constant DAC_ADDR
I2Cdata  out  16  write word
I2Cbytes  out  1  1 = two-byte transfer
I2Cr_w  out  1  0 = write
I2C_load  out  1  one-cycle start strobe
I2CBusy  in  1  I2C master busy
I2CDataReady  in  1  unused for writes; ignored
cmd_error  out  1  sticky flag, set on any error reply; cleared by rst or by the next 'K'

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. UART_Tx=0, UART_TxLoad=0, I2Cdata=0, I2Cbytes=1, I2Cr_w=0, I2C_load=0, cmd_error=0. Shift register, bit counter and timer are all cleared.
- Reset mid-operation: abort immediately, with no reply and no I2C_load. The I2C master is not notified.
- State IDLE: a 'V' strobe moves to GET_CH. All other bytes are ignored silently.
- State GET_CH: a digit d with d<CHANNELS is latched as the channel, then move to GET_BITS with the bit counter at 0.
  - Any other byte except 'V' gives error reply 'E'.
- State GET_BITS: '1' or '0' shifts in, MSB first, and increments the counter.
  - When the counter reaches DATA_BITS, move to LOAD on the next cycle.
  - Any other byte except 'V' gives reply 'E'.
- 'V' received in GET_CH or GET_BITS restarts parsing: go to GET_CH, discard the partial command, send no reply.
- State LOAD (one cycle): drive I2Cdata[15:12]=channel and I2Cdata[11:0]=code<<(12-DATA_BITS). Pulse I2C_load=1, then move to WAIT_START.
  - I2Cdata is held until the next LOAD.
- State WAIT_START: I2CBusy=1 moves to WAIT_END.
- State WAIT_END: I2CBusy=0 moves to REPLY with byte 'K'.
- Timeout: the timer clears on every accepted byte and on every state change.
  - Reaching TIMEOUT_CYCLES in GET_CH, GET_BITS, WAIT_START or WAIT_END gives reply 'T'.
- State REPLY (one cycle): pulse UART_TxLoad with UART_Tx = the reply byte, then return to IDLE.
  - 'E' and 'T' set cmd_error; 'K' clears it.
- UART strobes arriving during LOAD, WAIT_*, or REPLY are dropped. A 'V' arriving there is not queued.
- Latency: from the last data-digit strobe to I2C_load is exactly 2 clocks. From I2CBusy falling to UART_TxLoad is exactly 2 clocks.
- Bytes are compared to the full 8 bits; upper-case 'V' only.

Decomposition:
- Shared package dac_pkg holds:
  - state enum (IDLE, GET_CH, GET_BITS, LOAD, WAIT_START, WAIT_END, REPLY);
  - ASCII constants CMD_V, ACK_K, ERR_E, ERR_T;
  - the I2Cdata field positions.
- One natural sub-module, ascii_digit_decode. It is combinational and gives is_digit, is_bit and value[3:0] from a byte. The FSM, counters and timer stay in the top module.

Test Plan:
- Defaults, "V","2","101010101010", and the I2C model raises I2CBusy 3 clocks after load for 20 clocks -> one I2C_load, I2Cdata=16'h2AAA, I2Cr_w=0, I2Caddr=7'h4C, then UART_Tx='K' with one UART_TxLoad and cmd_error=0.
- DATA_BITS=8, "V","1","11110000" -> I2Cdata=16'h1F00; 2 clocks from the last strobe to I2C_load.
- "V","7" with CHANNELS=4 -> reply 'E', cmd_error=1, no I2C_load. A following valid command -> 'K' and cmd_error=0.
- "V","0","10","V","3", then 12 ones -> a single load with I2Cdata=16'h3FFF and no 'E'. "x" sent mid-bits -> 'E'.
- TIMEOUT_CYCLES=50: "V","0", then silence -> 'T' exactly 50 clocks after the last strobe. I2CBusy never asserted after load -> 'T'.
- rst asserted during WAIT_END, plus UART bytes sent while busy -> all outputs at reset values, no reply; busy-time bytes produce no effect.
